register_file: RTL and testbench
================================

Name: register_file

Overview:
- Integer register file for the 64-bit core: 32 entries × 64 bits, two read ports and one write port.
- Sits between decode (read addresses) and writeback (write port).
- Entry 0 is hardwired to zero, RISC-V style.
- Reads are combinational; writes commit on the rising clock edge.

Parameters:
- DATA_WIDTH, 64, width of each register and of the data ports.
- ADDR_WIDTH, 5, address width; depth = 2**ADDR_WIDTH = 32 entries.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- write_en_i  input  1  write enable, sampled on rising edge.
- write_addr_i  input  ADDR_WIDTH  destination register index.
- write_data_i  input  DATA_WIDTH  data to write.
- read_addr1_i  input  ADDR_WIDTH  read port 1 index.
- read_addr2_i  input  ADDR_WIDTH  read port 2 index.
- read_data1_o  output  DATA_WIDTH  read port 1 data, combinational.
- read_data2_o  output  DATA_WIDTH  read port 2 data, combinational.

Behaviour:
- Storage: entries 1..31 are flops; entry 0 has no storage and always reads 0.
- Reset: on a rising edge with rst_i=1, all entries 1..31 are cleared to 0.
  - rst_i has priority over write_en_i; the write in that cycle is discarded.
  - After reset both outputs read 0 for every address.
- Write: on a rising edge with rst_i=0, write_en_i=1 and write_addr_i≠0, the entry at write_addr_i takes write_data_i.
  - Writes to address 0 are silently ignored.
  - With write_en_i=0, no entry changes.
- Read: read_dataN_o is a pure combinational function of read_addrN_i, storage and (optionally) the bypass.
  - No read latency; the value is valid in the same cycle the address is applied.
  - read_addrN_i=0 returns 0 unconditionally.
- Ports are independent: both may address the same entry, including the write target, with identical results.
- No X propagation from storage: every entry is defined after the first reset edge.
- Reset mid-operation: the write in the reset cycle is dropped; the bypass is suppressed while rst_i=1; contents read 0 from the cycle after the reset edge.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding. When rst_i=0, write_en_i=1, write_addr_i≠0 and write_addr_i equals read_addrN_i, read_dataN_o returns write_data_i in the same cycle, before the edge. Each port forwards independently.
- Not defined: reads return stored contents only. The new value is visible from the cycle after the write edge; same-cycle reads of the write target return the old value.

Test Plan:
- Reset clears storage: hold rst_i=1 for 2 edges, release -> read_data1_o = read_data2_o = 0 for addresses 0, 5, 20, 31.
- Back-to-back writes then dual read:
  - Write 0xCAFEBABECAFEBABE to x20, then 0xDECADEFACADECAFE to x5 on consecutive edges.
  - Set write_en_i=0, read_addr1_i=20, read_addr2_i=5 -> outputs 0xCAFEBABECAFEBABE and 0xDECADEFACADECAFE.
  - write_en_i=0 with write_data_i=0xBABEBEEFCAFEDEAD changes nothing.
- Same-cycle read of write target: write_en_i=1, write x19 = 0xCAFEBABE12345678, read_addr1_i=19, read_addr2_i=5.
  - With REGFILE_BYPASS_EN: port1 = 0xCAFEBABE12345678 before the edge.
  - Without: port1 = 0 before the edge, 0xCAFEBABE12345678 after.
  - Port2 = 0xDECADEFACADECAFE in both builds.
- Both ports same address: write x23 = 0xDEADBEEFBEEFDEAD, both read 23 -> both outputs equal 0xDEADBEEFBEEFDEAD (after the edge, or in the same cycle with bypass).
- x0 hardwired: write_en_i=1, write_addr_i=0, write_data_i=0x1234567887654321, both reads 0 -> outputs 0 before and after the edge, including with bypass; x23 still reads 0xDEADBEEFBEEFDEAD.
- Reset after activity: x19 and x20 hold nonzero values; assert rst_i for 3 edges with write_en_i=1 to x19 -> x19 and x20 read 0 after the first reset edge; the write is dropped.

Source files
------------

// File: rtl/register_file.sv
// 32 x 64-bit integer register file: two combinational read ports, one write port, x0 reads zero.
// Define REGFILE_BYPASS_EN to forward the write data to a read port that addresses the write target in the same cycle.
module register_file #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  write_en_i,
  input  logic [ADDR_WIDTH-1:0] write_addr_i,
  input  logic [DATA_WIDTH-1:0] write_data_i,
  input  logic [ADDR_WIDTH-1:0] read_addr1_i,
  input  logic [ADDR_WIDTH-1:0] read_addr2_i,
  output logic [DATA_WIDTH-1:0] read_data1_o,
  output logic [DATA_WIDTH-1:0] read_data2_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Entry 0 has no storage, so the array starts at index 1.
  logic [DATA_WIDTH-1:0] regs_q [1:DEPTH-1];
  logic [DATA_WIDTH-1:0] regs_d [1:DEPTH-1];

  always_comb begin
    for (int i = 1; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
      if (write_en_i && (write_addr_i == ADDR_WIDTH'(i))) begin
        regs_d[i] = write_data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 1; i < DEPTH; i++) begin
      if (rst_i) begin
        regs_q[i] <= '0;
      end else begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] data;
    data = '0;
    if (addr != '0) begin
`ifdef REGFILE_BYPASS_EN
      // Forwarding is held off during reset so the dropped write never becomes visible.
      if (!rst_i && write_en_i && (write_addr_i == addr)) begin
        data = write_data_i;
      end else begin
        data = regs_q[addr];
      end
`else
      data = regs_q[addr];
`endif
    end
    return data;
  endfunction

  assign read_data1_o = read_port(read_addr1_i);
  assign read_data2_o = read_port(read_addr2_i);

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus randomized traffic against an array model.
// Expectations follow REGFILE_BYPASS_EN when the same macro is defined for the bench.
module tb_register_file;

  localparam int DW = 64;
  localparam int AW = 5;

  logic          clk;
  logic          rst_i;
  logic          write_en_i;
  logic [AW-1:0] write_addr_i;
  logic [DW-1:0] write_data_i;
  logic [AW-1:0] read_addr1_i;
  logic [AW-1:0] read_addr2_i;
  logic [DW-1:0] read_data1_o;
  logic [DW-1:0] read_data2_o;

  int n_cmp = 0;
  int n_err = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [DW-1:0] mdl [32];

  register_file dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .write_en_i   (write_en_i),
    .write_addr_i (write_addr_i),
    .write_data_i (write_data_i),
    .read_addr1_i (read_addr1_i),
    .read_addr2_i (read_addr2_i),
    .read_data1_o (read_data1_o),
    .read_data2_o (read_data2_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference read: x0 is zero, optional same-cycle forwarding, otherwise the stored value.
  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (BYPASS && !rst_i && write_en_i && write_addr_i == a) return write_data_i;
    return mdl[a];
  endfunction

  // Advance one rising edge, apply the architectural update rules to the model, then step off the edge.
  task automatic tick();
    @(posedge clk);
    if (rst_i) begin
      for (int i = 0; i < 32; i++) mdl[i] = '0;
    end else if (write_en_i && write_addr_i != 0) begin
      mdl[write_addr_i] = write_data_i;
    end
    #1;
  endtask

  task automatic test_reset();
    int addrs [4] = '{0, 5, 20, 31};
    rst_i = 1'b1; write_en_i = 1'b1; write_addr_i = 5'd7; write_data_i = 64'hFFFF_0000_FFFF_0000;
    tick();
    tick();
    rst_i = 1'b0; write_en_i = 1'b0;
    foreach (addrs[k]) begin
      read_addr1_i = AW'(addrs[k]); read_addr2_i = AW'(addrs[k]);
      #1;
      n_cmp++;
      if (read_data1_o !== 64'd0) begin
        n_err++; $display("FAIL reset_p1 addr=%0d got=%h exp=0", addrs[k], read_data1_o);
      end
      n_cmp++;
      if (read_data2_o !== 64'd0) begin
        n_err++; $display("FAIL reset_p2 addr=%0d got=%h exp=0", addrs[k], read_data2_o);
      end
      $display("reset read addr=%0d p1=%h p2=%h", addrs[k], read_data1_o, read_data2_o);
    end
  endtask

  task automatic test_back_to_back();
    write_en_i = 1'b1; write_addr_i = 5'd20; write_data_i = 64'hCAFEBABECAFEBABE;
    tick();
    write_addr_i = 5'd5; write_data_i = 64'hDECADEFACADECAFE;
    tick();
    write_en_i = 1'b0; write_addr_i = 5'd20; write_data_i = 64'hBABEBEEFCAFEDEAD;
    read_addr1_i = 5'd20; read_addr2_i = 5'd5;
    for (int r = 0; r < 2; r++) begin
      #1;
      n_cmp++;
      if (read_data1_o !== 64'hCAFEBABECAFEBABE) begin
        n_err++; $display("FAIL b2b_x20 pass=%0d got=%h exp=cafebabecafebabe", r, read_data1_o);
      end
      n_cmp++;
      if (read_data2_o !== 64'hDECADEFACADECAFE) begin
        n_err++; $display("FAIL b2b_x5 pass=%0d got=%h exp=decadefacadecafe", r, read_data2_o);
      end
      $display("b2b read pass=%0d x20=%h x5=%h", r, read_data1_o, read_data2_o);
      tick();
    end
  endtask

  task automatic test_same_cycle();
    logic [DW-1:0] pre;
    write_en_i = 1'b1; write_addr_i = 5'd19; write_data_i = 64'hCAFEBABE12345678;
    read_addr1_i = 5'd19; read_addr2_i = 5'd5;
    pre = BYPASS ? 64'hCAFEBABE12345678 : 64'd0;
    #1;
    n_cmp++;
    if (read_data1_o !== pre) begin
      n_err++; $display("FAIL same_cycle_pre got=%h exp=%h", read_data1_o, pre);
    end
    n_cmp++;
    if (read_data2_o !== 64'hDECADEFACADECAFE) begin
      n_err++; $display("FAIL same_cycle_p2 got=%h exp=decadefacadecafe", read_data2_o);
    end
    tick();
    write_en_i = 1'b0;
    #1;
    n_cmp++;
    if (read_data1_o !== 64'hCAFEBABE12345678) begin
      n_err++; $display("FAIL same_cycle_post got=%h exp=cafebabe12345678", read_data1_o);
    end
    $display("same-cycle x19 pre=%h post=%h", pre, read_data1_o);
  endtask

  task automatic test_same_addr();
    write_en_i = 1'b1; write_addr_i = 5'd23; write_data_i = 64'hDEADBEEFBEEFDEAD;
    read_addr1_i = 5'd23; read_addr2_i = 5'd23;
    #1;
    if (BYPASS) begin
      n_cmp++;
      if (read_data1_o !== 64'hDEADBEEFBEEFDEAD || read_data2_o !== 64'hDEADBEEFBEEFDEAD) begin
        n_err++; $display("FAIL same_addr_fwd got=%h/%h exp=deadbeefbeefdead", read_data1_o, read_data2_o);
      end
    end
    tick();
    write_en_i = 1'b0;
    #1;
    n_cmp++;
    if (read_data1_o !== 64'hDEADBEEFBEEFDEAD) begin
      n_err++; $display("FAIL same_addr_p1 got=%h exp=deadbeefbeefdead", read_data1_o);
    end
    n_cmp++;
    if (read_data2_o !== 64'hDEADBEEFBEEFDEAD) begin
      n_err++; $display("FAIL same_addr_p2 got=%h exp=deadbeefbeefdead", read_data2_o);
    end
    $display("same-addr x23 p1=%h p2=%h", read_data1_o, read_data2_o);
  endtask

  task automatic test_x0();
    write_en_i = 1'b1; write_addr_i = 5'd0; write_data_i = 64'h1234567887654321;
    read_addr1_i = 5'd0; read_addr2_i = 5'd0;
    for (int r = 0; r < 2; r++) begin
      #1;
      n_cmp++;
      if (read_data1_o !== 64'd0 || read_data2_o !== 64'd0) begin
        n_err++; $display("FAIL x0_zero pass=%0d got=%h/%h exp=0", r, read_data1_o, read_data2_o);
      end
      $display("x0 write pass=%0d p1=%h p2=%h", r, read_data1_o, read_data2_o);
      if (r == 0) tick();
    end
    write_en_i = 1'b0; read_addr1_i = 5'd23;
    #1;
    n_cmp++;
    if (read_data1_o !== 64'hDEADBEEFBEEFDEAD) begin
      n_err++; $display("FAIL x0_x23_kept got=%h exp=deadbeefbeefdead", read_data1_o);
    end
  endtask

  task automatic test_reset_after_activity();
    rst_i = 1'b1; write_en_i = 1'b1; write_addr_i = 5'd19; write_data_i = 64'h0BAD0BAD0BAD0BAD;
    read_addr1_i = 5'd19; read_addr2_i = 5'd20;
    #1;
    n_cmp++;
    if (read_data1_o !== 64'hCAFEBABE12345678) begin
      n_err++; $display("FAIL rst_no_fwd got=%h exp=cafebabe12345678", read_data1_o);
    end
    for (int e = 0; e < 3; e++) begin
      tick();
      n_cmp++;
      if (read_data1_o !== 64'd0 || read_data2_o !== 64'd0) begin
        n_err++; $display("FAIL rst_clear edge=%0d got=%h/%h exp=0", e, read_data1_o, read_data2_o);
      end
      $display("reset edge=%0d x19=%h x20=%h", e, read_data1_o, read_data2_o);
    end
    rst_i = 1'b0; write_en_i = 1'b0;
    #1;
    n_cmp++;
    if (read_data1_o !== 64'd0) begin
      n_err++; $display("FAIL rst_write_dropped got=%h exp=0", read_data1_o);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] e1, e2;
    for (int t = 0; t < 400; t++) begin
      rst_i        = ($urandom_range(0, 39) == 0);
      write_en_i   = $urandom_range(0, 3) != 0;
      write_addr_i = AW'($urandom_range(0, 31));
      write_data_i = {$urandom, $urandom};
      read_addr1_i = ($urandom_range(0, 3) == 0) ? write_addr_i : AW'($urandom_range(0, 31));
      read_addr2_i = ($urandom_range(0, 3) == 0) ? read_addr1_i : AW'($urandom_range(0, 31));
      #1;
      e1 = exp_rd(read_addr1_i);
      e2 = exp_rd(read_addr2_i);
      n_cmp++;
      if (read_data1_o !== e1) begin
        n_err++; $display("FAIL rand_p1 t=%0d a=%0d got=%h exp=%h", t, read_addr1_i, read_data1_o, e1);
      end
      n_cmp++;
      if (read_data2_o !== e2) begin
        n_err++; $display("FAIL rand_p2 t=%0d a=%0d got=%h exp=%h", t, read_addr2_i, read_data2_o, e2);
      end
      $display("rand t=%0d rst=%0b we=%0b wa=%0d ra1=%0d p1=%h ra2=%0d p2=%h", t, rst_i, write_en_i,
               write_addr_i, read_addr1_i, read_data1_o, read_addr2_i, read_data2_o);
      tick();
    end
    rst_i = 1'b0; write_en_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; write_en_i = 1'b0; write_addr_i = '0; write_data_i = '0;
    read_addr1_i = '0; read_addr2_i = '0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    test_reset();
    test_back_to_back();
    test_same_cycle();
    test_same_addr();
    test_x0();
    test_reset_after_activity();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
